// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a first-word-fall-through byte FIFO.
// Frames are decoded on a debounced ps2_clk. Framing, parity and timeout faults raise sticky flags.
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          fclk, fclk_d, fall;
  logic [FW-1:0] fcnt;
  logic [1:0]    state;
  logic [2:0]    bitcnt;
  logic [7:0]    sh;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout, stop_ev, par_ok;
  logic          fe_set, pe_set, ov_set, push, pop;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2_clk;
      c_s2 <= c_s1;
      d_s1 <= ps2_data;
      d_s2 <= d_s1;
    end
  end

  // fclk follows c_s2 only after FILT_LEN consecutive cycles of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      fclk_d <= fclk;
      if (c_s2 != fclk) begin
        if (fcnt == FW'(FILT_LEN - 1)) begin
          fclk <= c_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall    = fclk_d & ~fclk;
  assign busy    = (state != IDLE);
  assign timeout = busy && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign stop_ev = fall && (state == STOP);
  assign par_ok  = ^{sh, par};
  assign fe_set  = timeout || (stop_ev && !d_s2);
  assign pe_set  = stop_ev && d_s2 && !par_ok;
  assign ov_set  = stop_ev && d_s2 && par_ok && full && !rd_en;
  assign push    = stop_ev && d_s2 && par_ok && (!full || rd_en);
  assign pop     = rd_en && !empty;

  // tcnt holds the number of cycles since the last in-frame falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (timeout || (fall && (state == STOP || (state == IDLE && d_s2))))
        tcnt <= '0;
      else if (fall)
        tcnt <= TW'(1);
      else if (busy)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      if (timeout) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!d_s2) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            sh     <= {d_s2, sh[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= d_s2;
            state <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // a set in the same cycle as err_clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pe_set) parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (fe_set) frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ov_set) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

endmodule
